// File: rtl/pipe_pkg.sv
// pipe_pkg: shared state encoding and register constants for the pipeline sequencing controller
package pipe_pkg;
    typedef enum logic [1:0] {
        RUN        = 2'd0,
        FETCH_WAIT = 2'd1,
        MDU_BUSY   = 2'd2
    } state_t;
    localparam logic [4:0] ZERO_REG = 5'd0;
endpackage

// File: rtl/hazard_detect.sv
// hazard_detect: combinational load-use comparator between the load in EX and the sources of ID
module hazard_detect
    import pipe_pkg::*;
(
    input  logic       mem_read,
    input  logic [4:0] ex_rt,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       uses_rt,
    output logic       lu
);
    assign lu = mem_read && ex_rt != ZERO_REG && (ex_rt == id_rs || (uses_rt && ex_rt == id_rt));
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline sequencing FSM arbitrating mul/div occupancy, fetch waits, load-use and branch flushes
module hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int MDU_LAT       = 4,
    parameter int FETCH_TIMEOUT = 255,
    parameter int CNT_W         = 16
)(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [4:0]       IFID_rs_i,
    input  logic [4:0]       IFID_rt_i,
    input  logic             uses_rt_i,
    input  logic             IDEX_MemRead_i,
    input  logic [4:0]       IDEX_rt_i,
    input  logic             branch_taken_i,
    input  logic             mdu_start_i,
    input  logic             imem_ready_i,
    input  logic             clr_cnt_i,
    output logic             imem_req_o,
    output logic             PCWrite_o,
    output logic             IFID_Stall_o,
    output logic             IFID_Flush_o,
    output logic             IDEX_Bubble_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic             fetch_err_o
);
    localparam logic [7:0] TMO      = 8'(FETCH_TIMEOUT);
    localparam logic [3:0] MDU_INIT = 4'(MDU_LAT - 1);
    state_t     state, state_nxt;
    logic [3:0] mdu_cnt, mdu_nxt;
    logic [7:0] wait_cnt, wait_nxt;
    logic       lu, freeze;
    hazard_detect u_detect (
        .mem_read (IDEX_MemRead_i),
        .ex_rt    (IDEX_rt_i),
        .id_rs    (IFID_rs_i),
        .id_rt    (IFID_rt_i),
        .uses_rt  (uses_rt_i),
        .lu       (lu)
    );
    // Priority: mul/div occupancy, then fetch wait, then load-use; anything else advances.
    always_comb begin
        state_nxt = RUN;
        mdu_nxt   = '0;
        wait_nxt  = '0;
        freeze    = 1'b1;
        if (state == MDU_BUSY) begin
            state_nxt = (mdu_cnt == 4'd1) ? RUN : MDU_BUSY;
            mdu_nxt   = mdu_cnt - 4'd1;
        end else if (!imem_ready_i) begin
            state_nxt = FETCH_WAIT;
            wait_nxt  = (state == RUN) ? 8'd1 : (wait_cnt == TMO) ? wait_cnt : wait_cnt + 8'd1;
        end else if (!lu) begin
            freeze    = 1'b0;
            state_nxt = mdu_start_i ? MDU_BUSY : RUN;
            mdu_nxt   = mdu_start_i ? MDU_INIT : 4'd0;
        end
    end
    assign imem_req_o    = rst_i;
    assign PCWrite_o     = rst_i && !freeze;
    assign IFID_Stall_o  = rst_i && freeze;
    assign IDEX_Bubble_o = !rst_i || freeze;
    assign IFID_Flush_o  = !rst_i || (!freeze && branch_taken_i);
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state       <= RUN;
            mdu_cnt     <= '0;
            wait_cnt    <= '0;
            stall_cnt_o <= '0;
            fetch_err_o <= 1'b0;
        end else begin
            state       <= state_nxt;
            mdu_cnt     <= mdu_nxt;
            wait_cnt    <= wait_nxt;
            stall_cnt_o <= clr_cnt_i ? '0 : (freeze && stall_cnt_o != '1) ? stall_cnt_o + CNT_W'(1) : stall_cnt_o;
            fetch_err_o <= fetch_err_o || wait_nxt == TMO;
        end
    end
endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage core.
- Generates PC write enable, IF/ID stall and flush, and ID/EX bubble insertion.
- Arbitrates between four sources: load-use hazards, taken branch/jump flushes, multi-cycle instruction-fetch waits, and fixed-latency multiply/divide occupancy.
- Keeps a saturating stall-cycle counter and a sticky fetch-timeout error.

Parameters:
MDU_LAT, 4, total EX occupancy cycles of a mul/div instruction (legal range 2..15)
FETCH_TIMEOUT, 255, consecutive fetch-wait cycles before fetch_err_o sets (1..255)
CNT_W, 16, stall counter width

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous reset, active-low
IFID_rs_i  in  5  rs field of the instruction in ID
IFID_rt_i  in  5  rt field of the instruction in ID
uses_rt_i  in  1  ID instruction reads rt as a source
IDEX_MemRead_i  in  1  instruction in EX is a load
IDEX_rt_i  in  5  load destination register in EX
branch_taken_i  in  1  ID resolved a taken branch or jump
mdu_start_i  in  1  ID instruction is mul/div
imem_ready_i  in  1  instruction memory returns a valid fetch this cycle
clr_cnt_i  in  1  synchronous clear of stall_cnt_o
imem_req_o  out  1  fetch request
PCWrite_o  out  1  PC update enable
IFID_Stall_o  out  1  hold IF/ID
IFID_Flush_o  out  1  flush IF/ID
IDEX_Bubble_o  out  1  zero ID/EX control fields
stall_cnt_o  out  CNT_W  cycles with PCWrite_o=0 (saturating)
fetch_err_o  out  1  sticky fetch-timeout flag

Behaviour:
- Reset (rst_i=0, asynchronous):
  - state=RUN, mdu_cnt=0, wait_cnt=0, stall_cnt_o=0, fetch_err_o=0.
  - Combinational outputs while in reset: PCWrite_o=0, IFID_Stall_o=0, IFID_Flush_o=1, IDEX_Bubble_o=1, imem_req_o=0.
- States: RUN, FETCH_WAIT, MDU_BUSY.
- "Freeze" means PCWrite_o=0, IFID_Stall_o=1, IDEX_Bubble_o=1, IFID_Flush_o=0.
- "Normal" means PCWrite_o=1, IFID_Stall_o=0, IDEX_Bubble_o=0, IFID_Flush_o=0.
- imem_req_o=1 in every state out of reset.
- Load-use hazard (lu) is the combinational condition:
  - IDEX_MemRead_i && IDEX_rt_i!=0 && (IDEX_rt_i==IFID_rs_i || (uses_rt_i && IDEX_rt_i==IFID_rt_i)).
- Priority, highest first:
  1. MDU_BUSY
  2. fetch wait (state FETCH_WAIT, or imem_ready_i=0)
  3. lu
  4. branch_taken_i
  5. normal
- RUN:
  - If imem_ready_i=0: freeze, next=FETCH_WAIT, wait_cnt=1.
  - Else if lu: freeze for exactly 1 cycle. branch_taken_i and mdu_start_i are ignored that cycle; the ID instruction re-presents next cycle.
  - Else if branch_taken_i: normal plus IFID_Flush_o=1 (one cycle).
  - Else: normal.
  - mdu_start_i issues when imem_ready_i=1 and lu=0. That cycle is normal (plus flush if a branch is taken). Next=MDU_BUSY, mdu_cnt=MDU_LAT-1.
- FETCH_WAIT:
  - While imem_ready_i=0: freeze; wait_cnt increments, saturating at FETCH_TIMEOUT. When wait_cnt reaches FETCH_TIMEOUT, fetch_err_o sets and holds until reset.
  - On imem_ready_i=1: outputs evaluated exactly as RUN with ready=1 (lu, branch, mdu rules apply that same cycle). Next=RUN or MDU_BUSY accordingly; wait_cnt=0.
  - A taken branch held in ID during the wait is flushed only on the exit cycle.
- MDU_BUSY:
  - Freeze regardless of other inputs.
  - mdu_cnt decrements each cycle; at mdu_cnt==1 next=RUN.
  - Result: MDU_LAT-1 frozen cycles follow the issue cycle.
  - imem_ready_i is not tracked in this state. On return to RUN it is evaluated normally.
- stall_cnt_o:
  - Increments on every out-of-reset cycle with PCWrite_o=0; saturates at all-ones.
  - clr_cnt_i=1 forces 0 and wins over increment.
- Reset asserted mid-MDU_BUSY or mid-FETCH_WAIT aborts immediately to reset values. No state survives.

Decomposition:
- Shared package (pipe_pkg) holds:
  - state encoding constants RUN=2'd0, FETCH_WAIT=2'd1, MDU_BUSY=2'd2;
  - the zero-register constant 5'd0.
- One natural sub-module: hazard_detect, the purely combinational lu comparator. The FSM, counters and priority mux stay in hazard_ctrl.

Test Plan:
- Load-use: IDEX_MemRead_i=1, IDEX_rt_i=8, IFID_rs_i=8 with ready=1 -> exactly 1 cycle of PCWrite_o=0, IFID_Stall_o=1, IDEX_Bubble_o=1. Same stimulus with IDEX_rt_i=0 -> no stall.
- Branch: branch_taken_i=1 for 1 cycle, no lu -> IFID_Flush_o=1 and PCWrite_o=1 that cycle. Branch plus lu in the same cycle -> stall only, flush 0, flush on the following cycle.
- Mul/div: mdu_start_i=1 with MDU_LAT=4 -> issue cycle normal, then exactly 3 frozen cycles, then normal; stall_cnt_o=3.
- Fetch wait: imem_ready_i=0 for 5 cycles with branch_taken_i held 1 -> 5 frozen cycles, IFID_Flush_o=1 on the ready cycle. With FETCH_TIMEOUT=3 -> fetch_err_o rises after the 3rd wait cycle and stays 1.
- Reset mid-MDU: rst_i=0 during the 2nd busy cycle -> outputs go to reset values immediately. After release, state is RUN and stall_cnt_o=0.
- Counter: CNT_W=4 with 20 stall cycles -> stall_cnt_o saturates at 15. clr_cnt_i=1 together with a stall -> 0.
